regfile_wb_ctrl: RTL and testbench

- Write-side initiator for the 32x32 register file. Drives its single write port (AD, DI, writeen) from two writeback sources.
- ALU source: fixed priority, never stalled.
- Memory-load source: buffered in a small FIFO with ready backpressure; drains in cycles when the ALU is not writing.
- Kills stale queued loads so a newer ALU write to the same register is never overwritten.

---
 rtl/regfile_wb_ctrl.sv | 173 +++++++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl
// ---------------------------------------------------------------------------
// This block is the write-side initiator for a 32x32 register file. It drives
// the single write port (AD, DI, writeen) from two writeback sources:
//   - ALU results have fixed priority and are never stalled.
//   - Load results are buffered in a DEPTH-entry FIFO that has ready
//     backpressure. The FIFO drains only in cycles where the ALU is not
//     writing.
// Each queued load carries a valid ("live") bit. When an ALU write to rd X is
// accepted, every queued load to X is killed. A load to X that arrives at the
// same edge is pushed already killed. As a result, an older load can never
// overwrite a younger ALU result.
//
// Optional build macro: WB_BYPASS_EN. It adds read-port forwarding
// (A1/A2, RQ1/RQ2 -> FQ1/FQ2).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   alu_valid  ALU result present this cycle
//   alu_rd     ALU destination register
//   alu_data   ALU result
//   mem_valid  load result offered
//   mem_rd     load destination register
//   mem_data   load result
//   mem_ready  FIFO can accept (combinational, not full)
//   AD         register-file write address (registered)
//   DI         register-file write data (registered)
//   writeen    register-file write enable (registered)
//   pending    FIFO occupancy, killed entries included (registered)
//   A1, A2     read addresses           (WB_BYPASS_EN only)
//   RQ1, RQ2   register-file read data  (WB_BYPASS_EN only)
//   FQ1, FQ2   forwarded read data      (WB_BYPASS_EN only)
// ---------------------------------------------------------------------------
module regfile_wb_ctrl #(
  parameter int DEPTH = 4,
  parameter int PW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [4:0]    alu_rd,
  input  logic [31:0]   alu_data,
  input  logic          mem_valid,
  input  logic [4:0]    mem_rd,
  input  logic [31:0]   mem_data,
  output logic          mem_ready,
  output logic [4:0]    AD,
  output logic [31:0]   DI,
  output logic          writeen,
  output logic [PW-1:0] pending
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]    A1,
  input  logic [4:0]    A2,
  input  logic [31:0]   RQ1,
  input  logic [31:0]   RQ2,
  output logic [31:0]   FQ1,
  output logic [31:0]   FQ2
`endif
);

  localparam int AW = $clog2(DEPTH);

  // FIFO storage. The data fields need no reset: an entry is only
  // consumed when the occupancy count says it was written.
  logic [4:0]       rd_mem   [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [DEPTH-1:0] live;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic             alu_go;
  logic             pop;
  logic             push;
  logic             push_killed;
  logic [DEPTH-1:0] kill_hit;
  logic [4:0]       head_rd;
  logic [31:0]      head_data;
  logic             head_live;

  // Readiness depends only on the full flag. A pop in this same cycle does
  // not open a slot until after the edge.
  assign mem_ready = (pending != PW'(DEPTH));

  // Writes to register 0 are dropped. Such loads still complete the
  // handshake, but they never occupy a slot.
  assign alu_go      = alu_valid && (alu_rd != 5'd0);
  assign pop         = !alu_go && (pending != '0);
  assign push        = mem_valid && mem_ready && (mem_rd != 5'd0);
  assign push_killed = alu_go && (mem_rd == alu_rd);

  assign head_rd   = rd_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
  assign head_live = live[rd_ptr];

  // One comparator per entry. It flags every queued load that is made stale
  // by the ALU write accepted at this edge.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_kill
      assign kill_hit[gi] = alu_go && (rd_mem[gi] == alu_rd);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= mem_rd;
      data_mem[wr_ptr] <= mem_data;
    end
  end

  // A pushed slot can never be the slot that a kill targets in a meaningful
  // way: the slot is free until this edge. So the push setting wins for
  // that slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr == AW'(i))) begin
          live[i] <= !push_killed;
        end else if (kill_hit[i]) begin
          live[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= '0;
    end else begin
      if (push) wr_ptr <= AW'(wr_ptr + 1'b1);
      if (pop)  rd_ptr <= AW'(rd_ptr + 1'b1);
      case ({push, pop})
        2'b10:   pending <= PW'(pending + 1'b1);
        2'b01:   pending <= PW'(pending - 1'b1);
        default: pending <= pending;
      endcase
    end
  end

  // Write port. AD/DI hold their last written value whenever nothing
  // (or only a killed entry) is written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      AD      <= '0;
      DI      <= '0;
      writeen <= 1'b0;
    end else if (alu_go) begin
      AD      <= alu_rd;
      DI      <= alu_data;
      writeen <= 1'b1;
    end else if (pop && head_live) begin
      AD      <= head_rd;
      DI      <= head_data;
      writeen <= 1'b1;
    end else begin
      writeen <= 1'b0;
    end
  end

`ifdef WB_BYPASS_EN
  // Covers the cycle where the register file still returns the old value
  // for a write that is being committed at the next edge.
  assign FQ1 = (writeen && (AD == A1) && (A1 != 5'd0)) ? DI : RQ1;
  assign FQ2 = (writeen && (AD == A2) && (A2 != 5'd0)) ? DI : RQ2;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl.
//
// Structure:
//   - The driver keeps a reference model: a queue of pending loads, each with
//     a live flag. For every cycle of stimulus, the driver pushes the writes
//     it expects onto a scoreboard queue.
//   - An independent monitor pops the scoreboard whenever the DUT raises
//     writeen, and checks that AD/DI hold while writeen is low.
//   - The driver also checks mem_ready and pending against the model.
module tb_regfile_wb_ctrl;

  localparam int DEPTH = 4;
  localparam int PW    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          alu_valid = 1'b0;
  logic [4:0]    alu_rd = '0;
  logic [31:0]   alu_data = '0;
  logic          mem_valid = 1'b0;
  logic [4:0]    mem_rd = '0;
  logic [31:0]   mem_data = '0;
  logic          mem_ready;
  logic [4:0]    AD;
  logic [31:0]   DI;
  logic          writeen;
  logic [PW-1:0] pending;
`ifdef WB_BYPASS_EN
  logic [4:0]    A1 = '0;
  logic [4:0]    A2 = '0;
  logic [31:0]   RQ1 = '0;
  logic [31:0]   RQ2 = '0;
  logic [31:0]   FQ1;
  logic [31:0]   FQ2;
`endif

  regfile_wb_ctrl #(.DEPTH(DEPTH), .PW(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .AD        (AD),
    .DI        (DI),
    .writeen   (writeen),
    .pending   (pending)
`ifdef WB_BYPASS_EN
    ,
    .A1        (A1),
    .A2        (A2),
    .RQ1       (RQ1),
    .RQ2       (RQ2),
    .FQ1       (FQ1),
    .FQ2       (FQ2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        live;
  } load_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  load_t model_q[$];
  wr_t   exp_q[$];
  int    checks = 0;
  int    errors = 0;
  logic [4:0]  last_ad = '0;
  logic [31:0] last_di = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: checks one write per edge at which writeen is high.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if (writeen === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got AD=%0d DI=0x%08h expected no write at %0t", AD, DI, $time);
          end else begin
            e = exp_q.pop_front();
            check("write_AD", 32'(AD), 32'(e.rd));
            check("write_DI", DI, e.data);
            $display("write rd=%0d data=0x%08h at %0t", e.rd, e.data, $time);
            last_ad = e.rd;
            last_di = e.data;
`ifdef WB_BYPASS_EN
            A1  = e.rd;
            RQ1 = ~e.data;
            A2  = 5'd0;
            RQ2 = 32'h1234_5678;
            #1;
            check("bypass_FQ1", FQ1, e.data);
            check("bypass_FQ2_r0", FQ2, 32'h1234_5678);
`endif
          end
        end else begin
          check("hold_AD", 32'(AD), 32'(last_ad));
          check("hold_DI", DI, last_di);
        end
      end
    end
  end

  // One cycle of stimulus. The model computes this edge's outcome from the
  // state the FIFO held before the edge.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
    bit    go;
    bit    rdy;
    load_t h;
    @(negedge clk);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = adat;
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = mdat;
    #1;
    rdy = (model_q.size() < DEPTH);
    check("mem_ready", 32'(mem_ready), 32'(rdy));
    go = av && (ard != 5'd0);
    if (go) begin
      exp_q.push_back('{rd: ard, data: adat});
      foreach (model_q[i]) if (model_q[i].rd == ard) model_q[i].live = 1'b0;
    end else if (model_q.size() > 0) begin
      h = model_q.pop_front();
      if (h.live) exp_q.push_back('{rd: h.rd, data: h.data});
    end
    if (mv && rdy && (mrd != 5'd0))
      model_q.push_back('{rd: mrd, data: mdat, live: !(go && (mrd == ard))});
    @(posedge clk);
    #1;
    check("pending", 32'(pending), 32'(model_q.size()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_writeen", 32'(writeen), 0);
    check("reset_pending", 32'(pending), 0);
    check("reset_mem_ready", 32'(mem_ready), 1);
    check("reset_AD", 32'(AD), 0);
    check("reset_DI", DI, 0);
    reset = 1'b0;

    // ALU only.
    step(1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0);
    idle(2);

    // Load is held back by three ALU cycles, then drains.
    step(1, 5'd3, 32'h3, 1, 5'd7, 32'h11);
    step(1, 5'd3, 32'h4, 0, 0, 0);
    step(1, 5'd3, 32'h5, 0, 0, 0);
    idle(3);

    // Fill the FIFO, offer while full, then drain across the pointer wrap.
    for (int i = 0; i < 5; i++) step(1, 5'd1, 32'(i), 1, 5'(10 + i), 32'h100 + 32'(i));
    step(0, 0, 0, 1, 5'd20, 32'h200);
    step(0, 0, 0, 1, 5'd21, 32'h201);
    idle(6);

    // Kill: the queued rd 9 load is made stale by the ALU write to rd 9.
    step(1, 5'd2, 32'h2, 1, 5'd9, 32'hAA);
    step(1, 5'd9, 32'hBB, 0, 0, 0);
    idle(3);
    // Same-edge kill of an incoming load.
    step(1, 5'd6, 32'h66, 1, 5'd6, 32'h77);
    idle(3);

    // Register 0 on both sources.
    step(1, 5'd0, 32'hFFFF, 1, 5'd0, 32'hEEEE);
    idle(2);

    // Reset mid-run with two queued loads.
    step(1, 5'd1, 32'h1, 1, 5'd12, 32'hC);
    step(1, 5'd1, 32'h2, 1, 5'd13, 32'hD);
    @(negedge clk);
    reset = 1'b1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    #1;
    check("midreset_writeen", 32'(writeen), 0);
    check("midreset_pending", 32'(pending), 0);
    check("midreset_mem_ready", 32'(mem_ready), 1);
    model_q.delete();
    exp_q.delete();
    last_ad = '0;
    last_di = '0;
    @(negedge clk);
    reset = 1'b0;
    idle(4);

    // Randomized traffic over a small register range to provoke kills.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom);
    idle(8);

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
